// File: rtl/wptr_full_level.sv
// Write-side pointer, full/almost-full flags, occupancy and sticky overflow
// for an asynchronous FIFO. All state is registered on wclk.
//
// Handshake: winc is accepted on a rising edge only when wfull is low. A write
// attempted while wfull is high is dropped, leaves the pointer unchanged and
// sets the sticky wovf flag.
module wptr_full_level #(
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_LVL = 14
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                ovf_clr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LVL);

  logic [ADDRSIZE:0] wbin_q,   wbin_d;
  logic [ADDRSIZE:0] wptr_q,   wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q,  wfull_d;
  logic              awfull_q, awfull_d;
  logic              wovf_q,   wovf_d;

  logic              push;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] occ_next;
  logic [ADDRSIZE:0] full_cmp;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of
  // every Gray bit from the MSB down to i.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    push      = winc & ~wfull_q;
    wbinnext  = wbin_q + {{ADDRSIZE{1'b0}}, push};
    wgraynext = (wbinnext >> 1) ^ wbinnext;
    // Modular subtraction keeps the occupancy correct across pointer wrap.
    occ_next  = wbinnext - rbin_s;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  end

  always_comb begin
    wbin_d   = wbinnext;
    wptr_d   = wgraynext;
    wlevel_d = occ_next;
    wfull_d  = (wgraynext == full_cmp);
    awfull_d = (occ_next >= AFULL_THR);
    wovf_d   = wovf_q;
    if (ovf_clr) begin
      wovf_d = 1'b0;
    end
    // An overflow in the same cycle as a clear must not be lost.
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wptr   = wptr_q;
  assign wlevel = wlevel_q;
  assign wfull  = wfull_q;
  assign awfull = awfull_q;
  assign wovf   = wovf_q;

endmodule

// File: doc/wptr_full_level.md
WPTR_FULL_LEVEL -- requirements
Module: wptr_full_level

Interface
REQ-001 Parameter ADDRSIZE, default 4: FIFO address width; depth = 2^ADDRSIZE; legal range ADDRSIZE >= 2.
REQ-002 Parameter AFULL_LVL, default 14: occupancy at which awfull asserts; legal range 1 <= AFULL_LVL <= 2^ADDRSIZE.
REQ-003 wclk  input  1  write-domain clock; all state updates on rising edge.
REQ-004 wrst_n  input  1  reset is synchronous and active-low.
REQ-005 winc  input  1  write request; accepted only when wfull=0.
REQ-006 wq2_rptr  input  ADDRSIZE+1  read pointer (Gray), already synchronized into wclk domain.
REQ-007 ovf_clr  input  1  clears sticky overflow flag.
REQ-008 wfull  output  1  registered full flag.
REQ-009 awfull  output  1  registered almost-full flag.
REQ-010 waddr  output  ADDRSIZE  memory write address (binary).
REQ-011 wptr  output  ADDRSIZE+1  registered Gray write pointer, for synchronization into read domain.
REQ-012 wlevel  output  ADDRSIZE+1  registered occupancy estimate, 0..2^ADDRSIZE.
REQ-013 wovf  output  1  sticky overflow error flag.

Function
REQ-014 Block SHALL hold binary pointer wbin (ADDRSIZE+1 bits); waddr SHALL equal wbin[ADDRSIZE-1:0].
REQ-015 wbinnext SHALL equal wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1); write while full SHALL not advance pointer.
REQ-016 wgraynext SHALL equal (wbinnext >> 1) XOR wbinnext; each edge wbin<=wbinnext, wptr<=wgraynext (wptr changes at most one bit per cycle).
REQ-017 wfull SHALL be registered from wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}; flag reflects state after the write accepted on the same edge (zero extra latency).
REQ-018 Block SHALL convert wq2_rptr Gray to binary rbin_s combinationally (bit i = XOR of bits ADDRSIZE..i).
REQ-019 wlevel SHALL be registered as (wbinnext - rbin_s) modulo 2^(ADDRSIZE+1); wrap of either pointer SHALL not corrupt the difference.
REQ-020 awfull SHALL be registered as (wbinnext - rbin_s) >= AFULL_LVL; with AFULL_LVL = 2^ADDRSIZE, awfull SHALL equal wfull.
REQ-021 wovf SHALL set on any cycle with winc=1 and wfull=1, SHALL clear on ovf_clr=1, and set SHALL win when both occur in the same cycle.
REQ-022 wq2_rptr advancing in the same cycle as an accepted write SHALL be used as sampled; both effects SHALL appear on the next edge.
REQ-023 wq2_rptr is pessimistic (stale); wfull/awfull SHALL deassert only after the synchronized pointer advances, never early.
REQ-024 Pointer wrap (wbin from 2^(ADDRSIZE+1)-1 to 0) SHALL be seamless; wptr wraps Gray 1 0...0 to 0...0.

Reset
REQ-025 With wrst_n=0 at a rising edge: wbin=0, wptr=0, waddr=0, wfull=0, awfull=0, wlevel=0, wovf=0, regardless of winc/ovf_clr.
REQ-026 Reset asserted mid-operation (including while full or overflowed) SHALL take effect at that edge; no state survives.
REQ-027 Reset SHALL not act asynchronously; outputs hold between edges while wrst_n=0.

Verification (ADDRSIZE=4, AFULL_LVL=14)
REQ-028 wrst_n=0 two cycles with winc=1, ovf_clr=0 -> all outputs 0 after first edge; no pointer advance.
REQ-029 wq2_rptr=0, winc=1 for 16 cycles -> awfull=1 after 14th edge, wfull=1 after 16th, wlevel=16, wptr=5'b11000, waddr=0.
REQ-030 Continue winc=1 while full -> wptr stays 5'b11000, wovf=1 next edge; then ovf_clr=1, winc=0 -> wovf=0; ovf_clr=1 with winc=1 while full -> wovf stays 1.
REQ-031 From full, set wq2_rptr=5'b00110 (binary 4) -> next edge wfull=0, awfull=0, wlevel=12; one write -> wlevel=13.
REQ-032 wq2_rptr=5'b11000 (binary 16) from full at wbin=16, then 16 writes -> wbin wraps to 0, wptr=5'b00000, wfull=1, wlevel=16.
REQ-033 Pulse wrst_n=0 one cycle while wfull=1, wovf=1 -> after that edge all outputs 0; next winc=1 -> waddr=1, wptr=5'b00001.
